// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Sequences data-memory accesses for load/store instructions. It takes the
// effective address and store data from the execute stage, then drives one
// request to the data memory port. The request is held until acknowledged.
// Byte enables and lane-replicated write data are generated here. Load data is
// returned sign- or zero-extended for writeback. The pipeline is stalled while
// an access is in flight.
//
// Parameters
//   TIMEOUT      cycles allowed in ACCESS without mem_ack before bus error
//   TO_W         width of the timeout counter (must hold TIMEOUT)
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   is_load      current instruction is a load (wins if is_store also high)
//   is_store     current instruction is a store
//   is_halt      blocks acceptance of a new access
//   mem_size     00 byte, 01 half, 10 word, 11 illegal
//   ld_unsigned  1 = zero-extend load, 0 = sign-extend
//   alu_result   effective address
//   rs2_data     store data
//   mem_rdata    read data, valid with mem_ack
//   mem_ack      memory completes the access this cycle
//   mem_req      request, held until mem_ack
//   mem_we       write strobe
//   mem_addr     word-aligned address
//   mem_be       byte enables
//   mem_wdata    lane-replicated store data
//   stall        pipeline hold
//   done         one-cycle completion pulse
//   load_data    extended load result, valid while done
//   misalign_err one-cycle pulse: misaligned address or illegal size
//   bus_err      one-cycle pulse: acknowledge timeout
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_halt,
    input  logic [1:0]  mem_size,
    input  logic        ld_unsigned,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10,
        ERR    = 2'b11
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);

    // Size/offset legality: byte anywhere, half on even, word on 4-byte boundary.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] ofs);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~ofs[0];
            SZ_WORD: ok = (ofs == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] ofs);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << ofs;
            SZ_HALF: be = 4'b0011 << ofs;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicating into every lane lets memory pick by byte enable alone.
    function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] wd;
        case (size)
            SZ_BYTE: wd = {4{data[7:0]}};
            SZ_HALF: wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] extend_load(input logic [1:0]  size,
                                                input logic        uns,
                                                input logic [1:0]  ofs,
                                                input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rdata >> {ofs, 3'b000};
        case (size)
            SZ_BYTE: res = {{24{~uns & sh[7]}}, sh[7:0]};
            SZ_HALF: res = {{16{~uns & sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    state_t            state_r;
    state_t            next_s;
    logic              start_s;
    logic              aligned_s;
    logic              in_access_s;
    logic              timeout_s;
    logic [31:0]       addr_r;
    logic              we_r;
    logic [3:0]        be_r;
    logic [31:0]       wdata_r;
    logic [1:0]        size_r;
    logic              uns_r;
    logic [1:0]        ofs_r;
    logic [TO_W-1:0]   cnt_r;
    logic [31:0]       ldata_r;
    logic              err_bus_r;

    assign start_s     = (is_load | is_store) & ~is_halt;
    assign aligned_s   = is_aligned(mem_size, alu_result[1:0]);
    assign in_access_s = (state_r == ACCESS);
    assign timeout_s   = (cnt_r == CNT_LAST);

    // Next-state decode.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    if (aligned_s) begin
                        next_s = ACCESS;
                    end else begin
                        next_s = ERR;
                    end
                end else begin
                    next_s = IDLE;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    next_s = RESP;
                end else if (timeout_s) begin
                    next_s = ERR;
                end else begin
                    next_s = ACCESS;
                end
            end
            RESP:    next_s = IDLE;
            ERR:     next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Request latch, timeout counter, load capture and error kind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r    <= 32'h0000_0000;
            we_r      <= 1'b0;
            be_r      <= 4'b0000;
            wdata_r   <= 32'h0000_0000;
            size_r    <= 2'b00;
            uns_r     <= 1'b0;
            ofs_r     <= 2'b00;
            cnt_r     <= '0;
            ldata_r   <= 32'h0000_0000;
            err_bus_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (start_s) begin
                        // Entering either ACCESS or ERR: a fresh ERR from here is a misalign.
                        err_bus_r <= 1'b0;
                        if (aligned_s) begin
                            addr_r  <= {alu_result[31:2], 2'b00};
                            we_r    <= ~is_load;
                            be_r    <= calc_be(mem_size, alu_result[1:0]);
                            wdata_r <= calc_wdata(mem_size, rs2_data);
                            size_r  <= mem_size;
                            uns_r   <= ld_unsigned;
                            ofs_r   <= alu_result[1:0];
                        end
                    end
                end
                ACCESS: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (mem_ack) begin
                        ldata_r <= we_r ? 32'h0000_0000
                                        : extend_load(size_r, uns_r, ofs_r, mem_rdata);
                    end else if (timeout_s) begin
                        err_bus_r <= 1'b1;
                    end
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    // Outputs decode straight from the state register, so reset clears them at once.
    assign mem_req      = in_access_s;
    assign mem_we       = in_access_s & we_r;
    assign mem_addr     = in_access_s ? addr_r  : 32'h0000_0000;
    assign mem_be       = in_access_s ? be_r    : 4'b0000;
    assign mem_wdata    = in_access_s ? wdata_r : 32'h0000_0000;
    assign stall        = ((state_r == IDLE) & start_s & aligned_s) | in_access_s;
    assign done         = (state_r == RESP);
    assign load_data    = (state_r == RESP) ? ldata_r : 32'h0000_0000;
    assign misalign_err = (state_r == ERR) & ~err_bus_r;
    assign bus_err      = (state_r == ERR) & err_bus_r;

endmodule
